// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice.
package alu_pkg;

    localparam int unsigned OPND_W = 32;
    localparam int unsigned RES_W  = 64;
    localparam int unsigned MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_ADD = 4'd0;
    localparam logic [MODE_W-1:0] MODE_SUB = 4'd1;
    localparam logic [MODE_W-1:0] MODE_AND = 4'd2;
    localparam logic [MODE_W-1:0] MODE_OR  = 4'd3;
    localparam logic [MODE_W-1:0] MODE_XOR = 4'd4;
    localparam logic [MODE_W-1:0] MODE_SLT = 4'd5;
    localparam logic [MODE_W-1:0] MODE_SRA = 4'd6;
    localparam logic [MODE_W-1:0] MODE_SRL = 4'd7;
    localparam logic [MODE_W-1:0] MODE_SLL = 4'd8;
    localparam logic [MODE_W-1:0] MODE_MUL = 4'd9;
    localparam logic [MODE_W-1:0] MODE_DIV = 4'd10;
    localparam logic [MODE_W-1:0] MODE_MAX = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first request above the last grant, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int unsigned w_cand;

    // Scan NUM_REQ candidates starting one past the previous winner.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = (32'(i_last) + k) % NUM_REQ;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = ID_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU among NUM_REQ requesters with round-robin arbitration.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*OPND_W-1:0]  req_a,
    input  logic [NUM_REQ*OPND_W-1:0]  req_b,
    input  logic [NUM_REQ*MODE_W-1:0]  req_mode,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [RES_W-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       alu_valid,
    output logic [OPND_W-1:0]          alu_a,
    output logic [OPND_W-1:0]          alu_b,
    output logic [MODE_W-1:0]          alu_mode,
    input  logic                       alu_ready,
    input  logic [RES_W-1:0]           alu_out
);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic [OPND_W-1:0]   r_a;
    logic [OPND_W-1:0]   r_b;
    logic [MODE_W-1:0]   r_mode;
    logic [ID_W-1:0]     r_cur_id;
    logic [ID_W-1:0]     r_last_gnt;
    logic [RES_W-1:0]    r_res;
    logic                r_err;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_done;
    logic                w_illegal;
    logic [OPND_W-1:0]   w_a_arr    [NUM_REQ];
    logic [OPND_W-1:0]   w_b_arr    [NUM_REQ];
    logic [MODE_W-1:0]   w_mode_arr [NUM_REQ];
    logic [OPND_W-1:0]   w_sel_a;
    logic [OPND_W-1:0]   w_sel_b;
    logic [MODE_W-1:0]   w_sel_mode;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_last_gnt),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Unpack per-requester operand fields and select the granted one.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_a_arr[i]    = req_a[i*OPND_W +: OPND_W];
            w_b_arr[i]    = req_b[i*OPND_W +: OPND_W];
            w_mode_arr[i] = req_mode[i*MODE_W +: MODE_W];
        end
        w_sel_a    = w_a_arr[w_idx];
        w_sel_b    = w_b_arr[w_idx];
        w_sel_mode = w_mode_arr[w_idx];
        w_illegal  = (w_sel_mode > MODE_MAX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode plus combinational accept strobe.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready = w_gnt;
                    w_accept  = 1'b1;
                    w_next    = w_illegal ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (alu_ready) begin
                    w_done = 1'b1;
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand, owner and result registers; illegal modes skip the ALU with a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= '0;
            r_cur_id   <= '0;
            r_last_gnt <= ID_W'(NUM_REQ - 1);
            r_res      <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_a        <= w_sel_a;
            r_b        <= w_sel_b;
            r_mode     <= w_sel_mode;
            r_cur_id   <= w_idx;
            r_last_gnt <= w_idx;
            r_res      <= '0;
            r_err      <= w_illegal;
        end else if (w_done) begin
            r_res      <= alu_out;
            r_err      <= 1'b0;
        end
    end

    // Response strobe to the owning requester only.
    always_comb begin
        rsp_valid = '0;
        if (r_state == ST_RESP) rsp_valid[r_cur_id] = 1'b1;
    end

    assign rsp_data  = r_res;
    assign rsp_err   = r_err;
    assign busy      = (r_state != ST_IDLE);
    assign alu_valid = (r_state == ST_BUSY);
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_mode  = r_mode;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural multi-cycle ALU model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
    logic [7:0]   req_mode;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         rsp_err;
    logic         busy;
    logic         alu_valid;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [3:0]   alu_mode;
    logic         alu_ready;
    logic [63:0]  alu_out;

    int n_cmp;
    int n_fail;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .alu_valid (alu_valid),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_ready (alu_ready),
        .alu_out   (alu_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: modes 0-8 answer the edge after valid, MUL/DIV take longer.
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_res;
    int          valid_cycles;

    function automatic logic [63:0] alu_fn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (m)
            MODE_ADD: begin
                s = {a[31], a} + {b[31], b};
                if (s[32] != s[31]) return {32'h0, s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF};
                return {32'h0, s[31:0]};
            end
            MODE_XOR: return {32'h0, a ^ b};
            MODE_MUL: return 64'(a) * 64'(b);
            MODE_DIV: return {a % b, a / b};
            default:  return 64'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_valid) valid_cycles <= valid_cycles + 1;
        if (rst) begin
            alu_ready <= 1'b0;
            alu_out   <= 64'h0;
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_res     <= 64'h0;
        end else begin
            alu_ready <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    alu_ready <= 1'b1;
                    alu_out   <= m_res;
                    m_busy    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (alu_valid && !alu_ready) begin
                if (alu_mode == MODE_MUL || alu_mode == MODE_DIV) begin
                    m_busy <= 1'b1;
                    m_cnt  <= (alu_mode == MODE_MUL) ? 3 : 5;
                    m_res  <= alu_fn(alu_mode, alu_a, alu_b);
                end else begin
                    alu_ready <= 1'b1;
                    alu_out   <= alu_fn(alu_mode, alu_a, alu_b);
                end
            end
        end
    end

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
        req_a[p*32 +: 32]  = a;
        req_b[p*32 +: 32]  = b;
        req_mode[p*4 +: 4] = m;
    endtask

    function automatic logic [31:0] op_a(input int p, input int k);
        return 32'hA5A5_0000 | 32'(p * 16 + k);
    endfunction

    function automatic logic [31:0] op_b(input int p, input int k);
        return 32'h0F0F_F0F0 + 32'(k * 3 + p);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_a = '0; req_b = '0; req_mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid got %b want 0", alu_valid); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_sat();
        set_port(0, 32'h7FFF_FFFF, 32'h1, MODE_ADD);
        req_valid = 2'b01;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_ready got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n_cmp++; if (alu_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL add_c1_busy got v=%b b=%b want 1 1", alu_valid, busy); end
        n_cmp++; if (alu_a !== 32'h7FFF_FFFF || alu_b !== 32'h1 || alu_mode !== MODE_ADD) begin n_fail++; $display("FAIL add_alu_ops got %h %h %h", alu_a, alu_b, alu_mode); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL add_ready_busy got %b want 00", req_ready); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_c2_rsp got %b want 00", rsp_valid); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL add_c3_rsp_valid got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'h0000_0000_7FFF_FFFF) begin n_fail++; $display("FAIL add_rsp_data got %h want 000000007fffffff", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL add_c3_alu_valid got %b want 0", alu_valid); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_c4_idle got busy=%b rsp=%b want 0 00", busy, rsp_valid); end
    endtask

    task automatic test_long_op(input string nm, input int p, input logic [3:0] m,
                                input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_d);
        int t;
        logic [1:0] exp_g;
        exp_g = (p == 0) ? 2'b01 : 2'b10;
        set_port(p, a, b, m);
        req_valid = exp_g;
        #1;
        n_cmp++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL %s_ready got %b want %b", nm, req_ready, exp_g); end
        @(negedge clk);
        req_valid = 2'b00;
        t = 0;
        while (alu_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin n_cmp++; n_fail++; $display("FAIL %s_timeout got no alu_ready want alu_ready", nm); end
        @(negedge clk);
        n_cmp++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_after_ready got %b want 0", nm, alu_valid); end
        n_cmp++; if (rsp_valid !== exp_g) begin n_fail++; $display("FAIL %s_rsp_valid got %b want %b", nm, rsp_valid, exp_g); end
        n_cmp++; if (rsp_data !== exp_d) begin n_fail++; $display("FAIL %s_rsp_data got %h want %h", nm, rsp_data, exp_d); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL %s_rsp_err got %b want 0", nm, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int v0;
        v0 = valid_cycles;
        set_port(0, 32'h1234, 32'h5678, 4'd12);
        req_valid = 2'b01;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_ready got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL ill_rsp_valid got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL ill_rsp_err got %b want 1", rsp_err); end
        n_cmp++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL ill_rsp_data got %h want 0", rsp_data); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ill_idle got busy=%b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (valid_cycles !== v0) begin n_fail++; $display("FAIL ill_alu_untouched got %0d valid cycles want 0", valid_cycles - v0); end
    endtask

    task automatic test_back_to_back();
        int k [2];
        int t;
        int g;
        logic [1:0]  exp_g;
        logic [63:0] exp_d;
        k[0] = 0; k[1] = 0;
        set_port(0, op_a(0, 0), op_b(0, 0), MODE_XOR);
        set_port(1, op_a(1, 0), op_b(1, 0), MODE_XOR);
        req_valid = 2'b11;
        #1;
        for (int op = 0; op < 6; op++) begin
            g     = op % 2;
            exp_g = (g == 0) ? 2'b01 : 2'b10;
            exp_d = {32'h0, op_a(g, k[g]) ^ op_b(g, k[g])};
            t = 0;
            while (req_ready === 2'b00 && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) begin n_cmp++; n_fail++; $display("FAIL b2b_ready_timeout op=%0d got 00 want %b", op, exp_g); end
            n_cmp++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL b2b_grant op=%0d got %b want %b", op, req_ready, exp_g); end
            @(negedge clk);
            k[g]++;
            if (k[g] < 3) set_port(g, op_a(g, k[g]), op_b(g, k[g]), MODE_XOR);
            else          req_valid[g] = 1'b0;
            t = 0;
            while (rsp_valid === 2'b00 && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) begin n_cmp++; n_fail++; $display("FAIL b2b_rsp_timeout op=%0d got 00 want %b", op, exp_g); end
            n_cmp++; if (rsp_valid !== exp_g) begin n_fail++; $display("FAIL b2b_rsp_valid op=%0d got %b want %b", op, rsp_valid, exp_g); end
            n_cmp++; if (rsp_data !== exp_d) begin n_fail++; $display("FAIL b2b_rsp_data op=%0d got %h want %h", op, rsp_data, exp_d); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        set_port(0, 32'hFFFF_FFFF, 32'h2, MODE_MUL);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        n_cmp++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got alu_valid=%b want 1", alu_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after got %b want 0", busy); end
        n_cmp++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_alu_valid got %b want 0", alu_valid); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_rsp got %0d response cycles want 0", seen); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        valid_cycles = 0;
        test_reset();
        test_add_sat();
        test_long_op("div", 0, MODE_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        test_illegal();
        test_long_op("mul", 1, MODE_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
